// File: rtl/e_pkg.sv
// ---------------------------------------------------------------------------
// e_pkg
//   Shared types and helpers for the e_stream unary-code admission engine.
//   - mode_t  : per-beat admission mode (TRUE / CMPL / EITHER / NONE)
//   - len_w() : width of a decoded length field for a W-bit lane
//   - sat_add : saturating add used by the statistics counters
// ---------------------------------------------------------------------------
package e_pkg;

    typedef enum logic [1:0] {
        MODE_TRUE   = 2'b00,
        MODE_CMPL   = 2'b01,
        MODE_EITHER = 2'b10,
        MODE_NONE   = 2'b11
    } mode_t;

    // Admitted lengths run 1..W-1, so $clog2(W) bits always suffice.
    function automatic int len_w(input int w);
        return $clog2(w);
    endfunction

    // a + b clamped to max_val. The sum is formed one bit wider so that a
    // carry out of 32 bits is still seen as an overflow.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_val);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, max_val}) begin
            return max_val;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/e_lane.sv
// ---------------------------------------------------------------------------
// e_lane
//   Purely combinational classifier for one W-bit lane.
//   Ports:
//     i_x        in  W      : lane vector
//     i_mode     in  mode_t : admission mode for the beat
//     o_is_unary out 1      : lane admitted
//     o_cmp      out 1      : admitted form is the complement form
//     o_len      out LEN_W  : decoded length (0 when rejected)
// ---------------------------------------------------------------------------
module e_lane
    import e_pkg::*;
#(
    parameter int W                     = 16,
    parameter bit P_ADMIT_COMPLIMENT_EN = 1'b1,
    localparam int LEN_W                = len_w(W)
) (
    input  logic [W-1:0]     i_x,
    input  mode_t            i_mode,
    output logic             o_is_unary,
    output logic             o_cmp,
    output logic [LEN_W-1:0] o_len
);

    logic [W-1:0] w_inv;
    logic         w_true_shape;
    logic         w_cmpl_shape;
    logic         w_allow_true;
    logic         w_allow_cmpl;
    logic         w_take_true;
    logic         w_take_cmpl;
    logic [W-1:0] w_cnt_src;
    logic [LEN_W-1:0] w_ones;

    assign w_inv = ~i_x;

    // A run of low ones satisfies x & (x+1) == 0. All-zero and all-one also
    // satisfy it, so both are excluded explicitly; that also keeps k in 1..W-1.
    assign w_true_shape = ((i_x & (i_x + W'(1))) == '0) && (i_x != '0) && (i_x != '1);
    assign w_cmpl_shape = ((w_inv & (w_inv + W'(1))) == '0) && (w_inv != '0) && (w_inv != '1);

    assign w_allow_true = (i_mode == MODE_TRUE) || (i_mode == MODE_EITHER);
    assign w_allow_cmpl = P_ADMIT_COMPLIMENT_EN &&
                          ((i_mode == MODE_CMPL) || (i_mode == MODE_EITHER));

    // The two shapes are mutually exclusive, so no priority is really needed.
    assign w_take_true = w_true_shape && w_allow_true;
    assign w_take_cmpl = w_cmpl_shape && w_allow_cmpl && !w_take_true;

    // Length is the ones count of the true form or the zeros count of the
    // complement form; counting ones of ~x covers the latter.
    assign w_cnt_src = w_take_cmpl ? w_inv : i_x;

    always_comb begin
        w_ones = '0;
        for (int i = 0; i < W; i++) begin
            w_ones = w_ones + LEN_W'(w_cnt_src[i]);
        end
    end

    assign o_is_unary = w_take_true || w_take_cmpl;
    assign o_cmp      = w_take_cmpl;
    assign o_len      = o_is_unary ? w_ones : '0;

endmodule

// File: rtl/e_stream.sv
// ---------------------------------------------------------------------------
// e_stream
//   Two-stage pipelined, N-lane unary/thermometer admission and decode engine
//   with valid/ready handshakes and saturating accept/reject statistics.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     i_in_vld/o_in_rdy, i_in_x[N*W], i_in_mode[2] : input beat stream
//     o_out_vld/i_out_rdy, o_out_is_unary[N], o_out_cmp[N],
//     o_out_len[N*LEN_W], o_out_all               : result stream
//     i_stat_clr      : synchronous statistics clear (wins over a handshake)
//     o_stat_acc/o_stat_rej [CNT_W] : admitted / rejected lane counts
//   Note for integrators: o_in_rdy depends combinationally on i_out_rdy.
//   CNT_W must be 1..32, W >= 2, N >= 1.
// ---------------------------------------------------------------------------
module e_stream
    import e_pkg::*;
#(
    parameter int W                     = 16,
    parameter int N                     = 4,
    parameter bit P_ADMIT_COMPLIMENT_EN = 1'b1,
    parameter int CNT_W                 = 16,
    localparam int LEN_W                = len_w(W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_in_vld,
    output logic               o_in_rdy,
    input  logic [N*W-1:0]     i_in_x,
    input  logic [1:0]         i_in_mode,
    output logic               o_out_vld,
    input  logic               i_out_rdy,
    output logic [N-1:0]       o_out_is_unary,
    output logic [N-1:0]       o_out_cmp,
    output logic [N*LEN_W-1:0] o_out_len,
    output logic               o_out_all,
    input  logic               i_stat_clr,
    output logic [CNT_W-1:0]   o_stat_acc,
    output logic [CNT_W-1:0]   o_stat_rej
);

    localparam logic [31:0] C_CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    // Stage A: raw beat
    logic               r_a_vld;
    logic [N*W-1:0]     r_a_x;
    mode_t              r_a_mode;

    // Stage B: classified results
    logic               r_b_vld;
    logic [N-1:0]       r_b_is_unary;
    logic [N-1:0]       r_b_cmp;
    logic [N*LEN_W-1:0] r_b_len;

    logic [CNT_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_rej;

    logic               w_b_en;
    logic               w_a_en;
    logic               w_hs;
    logic [N-1:0]       w_is_unary;
    logic [N-1:0]       w_cmp;
    logic [N*LEN_W-1:0] w_len;
    logic [31:0]        w_pop;
    logic [31:0]        w_acc_next;
    logic [31:0]        w_rej_next;

    // Each stage advances when its downstream slot is empty or draining.
    assign w_b_en   = !r_b_vld || i_out_rdy;
    assign w_a_en   = !r_a_vld || w_b_en;
    assign w_hs     = r_b_vld && i_out_rdy;
    assign o_in_rdy = w_a_en && !rst;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            e_lane #(
                .W                     (W),
                .P_ADMIT_COMPLIMENT_EN (P_ADMIT_COMPLIMENT_EN)
            ) u_lane (
                .i_x        (r_a_x[gi*W +: W]),
                .i_mode     (r_a_mode),
                .o_is_unary (w_is_unary[gi]),
                .o_cmp      (w_cmp[gi]),
                .o_len      (w_len[gi*LEN_W +: LEN_W])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_vld  <= 1'b0;
            r_a_x    <= '0;
            r_a_mode <= MODE_TRUE;
        end else if (w_a_en) begin
            r_a_vld  <= i_in_vld;
            r_a_x    <= i_in_x;
            r_a_mode <= mode_t'(i_in_mode);
        end
    end

    // Bubbles load zeros so the result bus reads 0 whenever o_out_vld is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_b_vld      <= 1'b0;
            r_b_is_unary <= '0;
            r_b_cmp      <= '0;
            r_b_len      <= '0;
        end else if (w_b_en) begin
            r_b_vld      <= r_a_vld;
            r_b_is_unary <= r_a_vld ? w_is_unary : '0;
            r_b_cmp      <= r_a_vld ? w_cmp      : '0;
            r_b_len      <= r_a_vld ? w_len      : '0;
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N; i++) begin
            w_pop = w_pop + 32'(r_b_is_unary[i]);
        end
    end

    assign w_acc_next = sat_add(32'(r_acc), w_pop, C_CNT_MAX);
    assign w_rej_next = sat_add(32'(r_rej), 32'(N) - w_pop, C_CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst || i_stat_clr) begin
            r_acc <= '0;
            r_rej <= '0;
        end else if (w_hs) begin
            r_acc <= CNT_W'(w_acc_next);
            r_rej <= CNT_W'(w_rej_next);
        end
    end

    assign o_out_vld      = r_b_vld;
    assign o_out_is_unary = r_b_is_unary;
    assign o_out_cmp      = r_b_cmp;
    assign o_out_len      = r_b_len;
    assign o_out_all      = &r_b_is_unary;
    assign o_stat_acc     = r_acc;
    assign o_stat_rej     = r_rej;

endmodule

// File: tb/tb_e_stream.sv
module tb_e_stream;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int LW = 3;

    logic clk;
    logic rst;
    logic i_in_vld;
    logic [N*W-1:0] i_in_x;
    logic [1:0] i_in_mode;
    logic i_out_rdy;
    logic i_stat_clr;

    // DUT 1: complement admission on, 16-bit counters
    logic o_in_rdy, o_out_vld, o_out_all;
    logic [N-1:0] o_out_is_unary, o_out_cmp;
    logic [N*LW-1:0] o_out_len;
    logic [15:0] o_stat_acc, o_stat_rej;

    // DUT 2: complement admission off, 4-bit counters, same stimulus
    logic o_in_rdy2, o_out_vld2, o_out_all2;
    logic [N-1:0] o_out_is_unary2, o_out_cmp2;
    logic [N*LW-1:0] o_out_len2;
    logic [3:0] o_stat_acc2, o_stat_rej2;

    e_stream #(.W(W), .N(N), .P_ADMIT_COMPLIMENT_EN(1'b1), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .i_in_vld(i_in_vld), .o_in_rdy(o_in_rdy),
        .i_in_x(i_in_x), .i_in_mode(i_in_mode), .o_out_vld(o_out_vld),
        .i_out_rdy(i_out_rdy), .o_out_is_unary(o_out_is_unary),
        .o_out_cmp(o_out_cmp), .o_out_len(o_out_len), .o_out_all(o_out_all),
        .i_stat_clr(i_stat_clr), .o_stat_acc(o_stat_acc), .o_stat_rej(o_stat_rej)
    );

    e_stream #(.W(W), .N(N), .P_ADMIT_COMPLIMENT_EN(1'b0), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .i_in_vld(i_in_vld), .o_in_rdy(o_in_rdy2),
        .i_in_x(i_in_x), .i_in_mode(i_in_mode), .o_out_vld(o_out_vld2),
        .i_out_rdy(i_out_rdy), .o_out_is_unary(o_out_is_unary2),
        .o_out_cmp(o_out_cmp2), .o_out_len(o_out_len2), .o_out_all(o_out_all2),
        .i_stat_clr(i_stat_clr), .o_stat_acc(o_stat_acc2), .o_stat_rej(o_stat_rej2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] x;
        logic [1:0]  mode;
        int          age;   // edges seen since the accepting edge
    } beat_t;

    beat_t q[$];
    int m_acc, m_rej, m_acc2, m_rej2;

    // Classification straight from the code definitions: try every k.
    function automatic void ref_beat(input logic [31:0] x, input logic [1:0] mode,
                                     input bit padm, output logic [3:0] iu,
                                     output logic [3:0] cm, output logic [11:0] ln);
        iu = '0; cm = '0; ln = '0;
        for (int j = 0; j < N; j++) begin
            logic [7:0] v;
            logic [7:0] t;
            int kt, kc;
            v = x[j*8 +: 8];
            kt = 0; kc = 0;
            for (int k = 1; k < W; k++) begin
                t = 8'((1 << k) - 1);
                if (v == t) kt = k;
                if (v == ~t) kc = k;
            end
            if (kt != 0 && (mode == 2'd0 || mode == 2'd2)) begin
                iu[j] = 1'b1;
                ln[j*3 +: 3] = 3'(kt);
            end else if (kc != 0 && padm && (mode == 2'd1 || mode == 2'd2)) begin
                iu[j] = 1'b1;
                cm[j] = 1'b1;
                ln[j*3 +: 3] = 3'(kc);
            end
        end
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [7:0] rnd_lane();
        int k;
        k = $urandom_range(0, 8);
        case ($urandom_range(0, 3))
            0: return 8'((1 << k) - 1);
            1: return ~(8'((1 << k) - 1));
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rnd_beat();
        return {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()};
    endfunction

    // observation captured on the most recent handshake
    logic [3:0]  cap_iu, cap_cm, cap_iu2, cap_cm2;
    logic [11:0] cap_len, cap_len2;
    logic        cap_all;
    int cap_cnt = 0;
    int cyc = 0;
    int first_acc_cyc = -1;
    int first_hs_cyc = -1;
    bit obs_in_rdy, obs_vld, obs_acc;

    // One clock cycle: called at a negedge with inputs already driven.
    task automatic cycle();
        logic [3:0] eiu, ecm, eiu2, ecm2;
        logic [11:0] eln, eln2;
        bit exp_vld, exp_rdy, acc_now, hs_now;
        #1;
        exp_vld = (q.size() > 0) && (q[0].age >= 1);
        exp_rdy = !rst && ((q.size() < 2) || i_out_rdy);
        chk("in_rdy", o_in_rdy, exp_rdy);
        chk("in_rdy2", o_in_rdy2, exp_rdy);
        chk("out_vld", o_out_vld, exp_vld);
        chk("out_vld2", o_out_vld2, exp_vld);
        chk("acc", o_stat_acc, m_acc);
        chk("rej", o_stat_rej, m_rej);
        chk("acc2", o_stat_acc2, m_acc2);
        chk("rej2", o_stat_rej2, m_rej2);
        eiu = '0; eiu2 = '0;
        if (exp_vld) begin
            ref_beat(q[0].x, q[0].mode, 1'b1, eiu, ecm, eln);
            ref_beat(q[0].x, q[0].mode, 1'b0, eiu2, ecm2, eln2);
            chk("is_unary", o_out_is_unary, eiu);
            chk("cmp", o_out_cmp, ecm);
            chk("len", o_out_len, eln);
            chk("all", o_out_all, &eiu);
            chk("is_unary2", o_out_is_unary2, eiu2);
            chk("cmp2", o_out_cmp2, ecm2);
            chk("len2", o_out_len2, eln2);
            chk("all2", o_out_all2, &eiu2);
        end
        obs_in_rdy = o_in_rdy;
        obs_vld = o_out_vld;
        acc_now = i_in_vld && exp_rdy;
        obs_acc = i_in_vld && o_in_rdy;
        hs_now = exp_vld && i_out_rdy;
        if (acc_now && first_acc_cyc < 0) first_acc_cyc = cyc;
        if (hs_now) begin
            cap_iu = o_out_is_unary; cap_cm = o_out_cmp; cap_len = o_out_len;
            cap_all = o_out_all;
            cap_iu2 = o_out_is_unary2; cap_cm2 = o_out_cmp2; cap_len2 = o_out_len2;
            cap_cnt++;
            if (first_hs_cyc < 0) first_hs_cyc = cyc;
            $display("beat out: x=%08h mode=%0d iu=%b cmp=%b len=%03h", q[0].x, q[0].mode,
                     o_out_is_unary, o_out_cmp, o_out_len);
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_acc = 0; m_rej = 0; m_acc2 = 0; m_rej2 = 0;
        end else begin
            if (i_stat_clr) begin
                m_acc = 0; m_rej = 0; m_acc2 = 0; m_rej2 = 0;
            end else if (hs_now) begin
                m_acc  = sat(m_acc + $countones(eiu), 65535);
                m_rej  = sat(m_rej + N - $countones(eiu), 65535);
                m_acc2 = sat(m_acc2 + $countones(eiu2), 15);
                m_rej2 = sat(m_rej2 + N - $countones(eiu2), 15);
            end
            if (hs_now) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (acc_now) begin
                beat_t b;
                b.x = i_in_x; b.mode = i_in_mode; b.age = 0;
                q.push_back(b);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        i_in_vld = 1'b0;
        i_out_rdy = 1'b1;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(input logic [31:0] x, input logic [1:0] mode);
        i_in_vld = 1'b1;
        i_in_x = x;
        i_in_mode = mode;
        cycle();
        i_in_vld = 1'b0;
    endtask

    int cnt0, n_acc;

    initial begin
        rst = 1'b1; i_in_vld = 1'b0; i_in_x = '0; i_in_mode = 2'd0;
        i_out_rdy = 1'b1; i_stat_clr = 1'b0;
        m_acc = 0; m_rej = 0; m_acc2 = 0; m_rej2 = 0;
        @(negedge clk);
        cycle();
        rst = 1'b0;
        #1;
        chk("rst_vld", o_out_vld, 1'b0);
        chk("rst_iu", o_out_is_unary, 4'b0);
        chk("rst_cmp", o_out_cmp, 4'b0);
        chk("rst_len", o_out_len, 12'h0);
        chk("rst_all", o_out_all, 1'b0);
        chk("rst_acc", o_stat_acc, 16'd0);
        chk("rst_rej", o_stat_rej, 16'd0);
        chk("rst_in_rdy", o_in_rdy, 1'b1);

        // TRUE mode: lanes {07, F8, 00, 7F}
        send({8'h7F, 8'h00, 8'hF8, 8'h07}, 2'd0);
        idle(3);
        chk("true_iu", cap_iu, 4'b1001);
        chk("true_len", cap_len, 12'hE03);
        chk("true_cmp", cap_cm, 4'b0000);
        chk("true_all", cap_all, 1'b0);
        chk("true_acc", o_stat_acc, 16'd2);
        chk("true_rej", o_stat_rej, 16'd2);

        // EITHER mode: lanes {F8, FF, 01, FE}
        send({8'hFE, 8'h01, 8'hFF, 8'hF8}, 2'd2);
        idle(3);
        chk("either_iu", cap_iu, 4'b1101);
        chk("either_cmp", cap_cm, 4'b1001);
        chk("either_len", cap_len, 12'h243);
        chk("either_iu_nocmp", cap_iu2, 4'b0100);
        chk("either_cmp_nocmp", cap_cm2, 4'b0000);
        chk("either_acc", o_stat_acc, 16'd5);
        chk("either_rej", o_stat_rej, 16'd3);

        // NONE mode on the same beat
        send({8'hFE, 8'h01, 8'hFF, 8'hF8}, 2'd3);
        idle(3);
        chk("none_iu", cap_iu, 4'b0000);
        chk("none_iu2", cap_iu2, 4'b0000);
        chk("none_rej", o_stat_rej, 16'd7);

        // Backpressure: three back-to-back beats into a stalled output
        cnt0 = cap_cnt;
        n_acc = 0;
        i_out_rdy = 1'b0;
        i_in_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_in_x = rnd_beat(); i_in_mode = 2'($urandom_range(0, 3));
            cycle();
            if (obs_acc) n_acc++;
        end
        chk("bp_accepted", n_acc, 2);
        chk("bp_rdy_third", obs_in_rdy, 1'b0);
        for (int i = 0; i < 4; i++) cycle();
        i_out_rdy = 1'b1;
        for (int i = 0; i < 4 && n_acc < 3; i++) begin
            cycle();
            if (obs_acc) n_acc++;
        end
        idle(4);
        chk("bp_emerged", cap_cnt - cnt0, 3);

        // Saturation on the 4-bit counters
        i_stat_clr = 1'b1; cycle(); i_stat_clr = 1'b0;
        chk("clr_acc2", o_stat_acc2, 4'd0);
        i_in_vld = 1'b1; i_in_x = 32'h7F3F0F01; i_in_mode = 2'd0;
        for (int i = 0; i < 5; i++) cycle();
        idle(3);
        chk("sat_acc2", o_stat_acc2, 4'd15);
        chk("sat_rej2", o_stat_rej2, 4'd0);
        chk("sat_acc", o_stat_acc, 16'd20);

        // Clear coincident with a handshake
        send(32'h7F3F0F01, 2'd0);
        idle(1);
        i_stat_clr = 1'b1;
        cycle();
        i_stat_clr = 1'b0;
        chk("clrhs_vld", obs_vld, 1'b1);
        chk("clrhs_acc", o_stat_acc, 16'd0);
        chk("clrhs_rej", o_stat_rej, 16'd0);
        chk("clrhs_acc2", o_stat_acc2, 4'd0);

        // Throughput: 100 beats with the output always ready
        cnt0 = cap_cnt; n_acc = 0; first_acc_cyc = -1; first_hs_cyc = -1;
        i_out_rdy = 1'b1; i_in_vld = 1'b1;
        for (int i = 0; i < 100; i++) begin
            i_in_x = rnd_beat(); i_in_mode = 2'($urandom_range(0, 3));
            cycle();
            if (obs_acc) n_acc++;
        end
        idle(3);
        chk("tp_accepted", n_acc, 100);
        chk("tp_latency", first_hs_cyc - first_acc_cyc, 2);
        chk("tp_emerged", cap_cnt - cnt0, 100);

        // Random traffic with random stalls and occasional clears
        for (int i = 0; i < 1500; i++) begin
            i_in_vld = ($urandom_range(0, 3) != 0);
            i_in_x = rnd_beat();
            i_in_mode = 2'($urandom_range(0, 3));
            i_out_rdy = ($urandom_range(0, 9) < 7);
            i_stat_clr = ($urandom_range(0, 49) == 0);
            cycle();
        end
        i_stat_clr = 1'b0;
        idle(4);

        // Reset mid-stream with both stages full
        i_out_rdy = 1'b0; i_in_vld = 1'b1;
        for (int i = 0; i < 2; i++) begin
            i_in_x = rnd_beat(); i_in_mode = 2'd2;
            cycle();
        end
        i_in_vld = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        chk("mrst_vld", o_out_vld, 1'b0);
        chk("mrst_acc", o_stat_acc, 16'd0);
        chk("mrst_rej", o_stat_rej, 16'd0);
        chk("mrst_in_rdy", o_in_rdy, 1'b1);
        cnt0 = cap_cnt;
        idle(4);
        chk("mrst_no_stale", cap_cnt - cnt0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/e_stream.md
# e_stream

Pipelined, multi-lane unary/thermometer-code admission and decode engine. Each accepted beat carries `N` lanes of `W`-bit vectors. Per lane, the block classifies the vector as a true-form unary code, a complement-form unary code, or invalid, and decodes its length. Results leave on a valid/ready stream, and saturating accept/reject statistics are maintained. It sits between a raw code source and downstream consumers that need admitted lengths rather than raw vectors.

## Interface
Parameters:
- `W`, 16: lane bit-width; must be ≥ 2.
- `N`, 4: lane count; must be ≥ 1.
- `P_ADMIT_COMPLIMENT_EN`, 1: when 0, complement forms are never admitted, regardless of mode.
- `CNT_W`, 16: statistics counter width.

Ports:
- `clk`  in  1: clock. Single clock domain.
- `rst`  in  1: reset, synchronous, active-high.
- `i_in_vld`  in  1: input beat valid.
- `o_in_rdy`  out  1: input beat ready.
- `i_in_x`  in  N*W: lane vectors; lane j occupies bits [j*W +: W].
- `i_in_mode`  in  2: 00 TRUE, 01 CMPL, 10 EITHER, 11 NONE. Sampled with the beat.
- `o_out_vld`  out  1: result valid.
- `i_out_rdy`  in  1: result ready.
- `o_out_is_unary`  out  N: per-lane admit flag.
- `o_out_cmp`  out  N: per-lane flag, set when the admitted form is the complement form.
- `o_out_len`  out  N*LEN_W: per-lane decoded length, with LEN_W = $clog2(W).
- `o_out_all`  out  1: AND of `o_out_is_unary`.
- `i_stat_clr`  in  1: synchronous statistics clear.
- `o_stat_acc`  out  CNT_W: count of admitted lanes.
- `o_stat_rej`  out  CNT_W: count of rejected lanes.

## Operation
- True form of length k: x == (1<<k)-1, with 1 ≤ k ≤ W-1.
- Complement form of length k: x == ~((1<<k)-1), with the same k range.
- All-zero and all-one vectors are never admitted in any mode.
- Admission by mode:
  - TRUE: admit the true form only.
  - CMPL: admit the complement form only.
  - EITHER: admit either form.
  - NONE: reject every lane.
- With P_ADMIT_COMPLIMENT_EN=0, CMPL admits nothing and EITHER behaves as TRUE.
- Admitted lane outputs:
  - `len` = k, which is the ones count for the true form and the zeros count for the complement form.
  - `cmp` = 1 if and only if the complement form was admitted.
- Rejected lane outputs: `len`=0 and `cmp`=0.
- Lane results are independent; one beat may mix admitted and rejected lanes.
- Statistics update only on an output handshake (`o_out_vld & i_out_rdy`):
  - `acc += popcount(is_unary)`
  - `rej += N - popcount(is_unary)`
  - Each counter saturates at all-ones and never wraps.
- `i_stat_clr` zeroes both counters on the next edge. It takes priority over a coincident handshake, whose contribution is dropped.

## Timing
- Two register stages:
  - Stage A captures `i_in_x` and `i_in_mode`.
  - Stage B holds the classified results.
- Latency: a beat accepted at edge t is presented on `o_out_vld` after edge t+1, i.e. 2 cycles accept-to-valid with no stall.
- Throughput: one beat per cycle when `i_out_rdy` is held high.
- Stage enables:
  - `b_en = ~b_vld | i_out_rdy`
  - `a_en = ~a_vld | b_en`
- `o_in_rdy = a_en & ~rst`. This is a combinational path from `i_out_rdy`; it is permitted and documented for the integrator.
- Handshake rules:
  - Output data and `o_out_vld` are held stable while `o_out_vld & ~i_out_rdy`.
  - Once `o_out_vld` asserts, it deasserts only after a handshake.
  - No beat is dropped or duplicated under any stall pattern.
  - At most 2 beats are in flight.
- Reset, on any cycle including mid-stream:
  - `a_vld`, `b_vld` and both counters go to 0 on the next edge.
  - All in-flight beats are discarded.
- Output values after reset: `o_out_vld`=0, `o_out_is_unary`=0, `o_out_cmp`=0, `o_out_len`=0, `o_out_all`=0, `o_stat_acc`=0, `o_stat_rej`=0. `o_in_rdy` is 0 while `rst` is high and 1 on the first cycle after.

## Structure
- Package `e_pkg` holds:
  - `mode_t`: 2-bit enum TRUE/CMPL/EITHER/NONE.
  - `len_w(W)`: function returning $clog2(W).
  - `sat_add`: saturating-add helper function.
- Sub-module `e_lane`: purely combinational per-lane classifier. It takes `x` and `mode` and produces `is_unary`, `cmp` and `len`, and is instantiated N times between stages A and B.
- The top level owns the pipeline registers, handshake logic and statistics counters.

## Test plan
All scenarios use W=8, N=4, CNT_W=16 unless stated.
- **TRUE mode:** mode TRUE, lanes {0x07, 0xF8, 0x00, 0x7F}, lane0 first → is_unary=4'b1001, len={3,0,0,7}, cmp=0, all=0; after the handshake acc=2, rej=2.
- **EITHER mode:** mode EITHER, lanes {0xF8, 0xFF, 0x01, 0xFE} → is_unary=4'b1101, cmp=4'b1001, len={3,0,1,1}. With P_ADMIT_COMPLIMENT_EN=0, the same beat gives is_unary=4'b0100. Mode NONE gives 0.
- **Backpressure:** hold `i_out_rdy`=0 and drive 3 beats back-to-back → 2 accepted, `o_in_rdy` falls on the third. Then release `i_out_rdy` → all 3 emerge in order, no loss or duplication, output stable throughout the stall.
- **Throughput:** 100 random beats with `i_out_rdy`=1 → one result per cycle, first result 2 cycles after the first accept. Results match a reference model.
- **Saturation and clear:** with CNT_W=4, send 5 all-admitted beats → acc saturates at 15, rej=0. Assert `i_stat_clr` coincident with a handshake → acc=0 and rej=0 next cycle.
- **Reset mid-stream:** with both stages full and `i_out_rdy`=0, pulse `rst` for 1 cycle → `o_out_vld`=0 and counters 0 on the next cycle. No stale beat emerges, and `o_in_rdy`=1 the cycle after reset deasserts.
